// File: rtl/user_sram_bank.sv
// Single-port user SRAM bank: per-byte writes, 1- or 2-cycle registered reads
// with a valid strobe, and a clear engine that zeroes one word per cycle.
module user_sram_bank #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_BIT       = 8,
  parameter int unsigned RD_LAT         = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   be_i,
  input  logic [ADDR_BIT-1:0]   addr_i,
  input  logic [DATA_W-1:0]     di_i,
  input  logic                  clr_i,
  output logic                  ready_o,
  output logic [DATA_W-1:0]     do_o,
  output logic                  rvalid_o,
  output logic                  busy_o
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_BIT;

  generate
    if (DATA_W % 8 != 0) begin : g_bad_data_w
      $error("user_sram_bank: DATA_W must be a multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("user_sram_bank: RD_LAT must be 1 or 2");
    end
  endgenerate

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e              state_q, state_d;
  logic [ADDR_BIT-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                mem_we;
  logic [ADDR_BIT-1:0] mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [NB-1:0]       mem_wbe;
  logic                rd_acc;

  logic [DATA_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d;
  logic                v1_q, v1_d, v2_q, v2_d;

  assign ready_o = (state_q == IDLE) && !clr_i;
  assign busy_o  = (state_q == CLEAR);
  assign rd_acc  = ready_o && req_i && !we_i;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = addr_i;
    mem_wdata = di_i;
    mem_wbe   = be_i;
    unique case (state_q)
      IDLE: begin
        if (clr_i) state_d = CLEAR;
        else if (req_i && we_i) mem_we = 1'b1;
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        mem_wbe   = '1;
        clr_cnt_d = ADDR_BIT'(clr_cnt_q + 1'b1);
        if (clr_cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The array has no reset; keep the clear engine from writing while held in reset.
    if (rst_i) mem_we = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (mem_wbe[b]) mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Data registers only load on a completing read so do_o holds between reads.
  always_comb begin
    v1_d  = rd_acc;
    rd1_d = rd_acc ? mem_q[addr_i] : rd1_q;
    v2_d  = v1_q;
    rd2_d = v1_q ? rd1_q : rd2_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q  <= 1'b0;
      rd1_q <= '0;
      v2_q  <= 1'b0;
      rd2_q <= '0;
    end else begin
      v1_q  <= v1_d;
      rd1_q <= rd1_d;
      v2_q  <= v2_d;
      rd2_q <= rd2_d;
    end
  end

  assign do_o     = (RD_LAT == 2) ? rd2_q : rd1_q;
  assign rvalid_o = (RD_LAT == 2) ? v2_q  : v1_q;

endmodule

// File: tb/tb_user_sram_bank.sv
// Bench for user_sram_bank: three instances (32b/RD_LAT=1, 32b/RD_LAT=2, 64b without reset clear)
// with a read scoreboard keyed on the cycle each rvalid is due.
module tb_user_sram_bank;
  logic clk;
  logic rst;

  logic        req, we, clr;
  logic [3:0]  be, addr;
  logic [31:0] di;
  logic        ready_a, rvalid_a, busy_a, ready_b, rvalid_b, busy_b;
  logic [31:0] do_a, do_b;

  logic        req_c, we_c, clr_c;
  logic [7:0]  be_c;
  logic [3:0]  addr_c;
  logic [63:0] di_c, do_c;
  logic        ready_c, rvalid_c, busy_c;

  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  exp_t        qa[$], qb[$], qc[$];
  logic [31:0] model_ab [16];
  logic [63:0] model_c [16];
  int          cyc, total, bad, n;

  user_sram_bank #(.DATA_W(32), .ADDR_BIT(4), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .di_i(di),
    .clr_i(clr), .ready_o(ready_a), .do_o(do_a), .rvalid_o(rvalid_a), .busy_o(busy_a));

  user_sram_bank #(.DATA_W(32), .ADDR_BIT(4), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .di_i(di),
    .clr_i(clr), .ready_o(ready_b), .do_o(do_b), .rvalid_o(rvalid_b), .busy_o(busy_b));

  user_sram_bank #(.DATA_W(64), .ADDR_BIT(4), .RD_LAT(1), .CLEAR_ON_RESET(0)) u_c (
    .clk_i(clk), .rst_i(rst), .req_i(req_c), .we_i(we_c), .be_i(be_c), .addr_i(addr_c), .di_i(di_c),
    .clr_i(clr_c), .ready_o(ready_c), .do_o(do_c), .rvalid_o(rvalid_c), .busy_o(busy_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] ben);
    logic [63:0] r;
    r = old;
    for (int k = 0; k < 8; k++) if (ben[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  // One clock: sample #1 after the edge and check every bank's rvalid/do_o against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (qa.size() > 0 && qa[0].due == cyc) begin
      e = qa.pop_front();
      chk("rvalid_a", rvalid_a, 1);
      chk("do_a", do_a, e.data);
    end else chk("rvalid_a_idle", rvalid_a, 0);
    if (qb.size() > 0 && qb[0].due == cyc) begin
      e = qb.pop_front();
      chk("rvalid_b", rvalid_b, 1);
      chk("do_b", do_b, e.data);
    end else chk("rvalid_b_idle", rvalid_b, 0);
    if (qc.size() > 0 && qc[0].due == cyc) begin
      e = qc.pop_front();
      chk("rvalid_c", rvalid_c, 1);
      chk("do_c", do_c, e.data);
    end else chk("rvalid_c_idle", rvalid_c, 0);
  endtask

  task automatic wr_ab(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; we = 1'b1; addr = a; di = d; be = b;
    chk("wr_ready_a", ready_a, 1);
    chk("wr_ready_b", ready_b, 1);
    tick();
    model_ab[a] = 32'(merge({32'h0, model_ab[a]}, {32'h0, d}, {4'h0, b}));
    req = 1'b0;
  endtask

  task automatic rd_ab(input logic [3:0] a);
    req = 1'b1; we = 1'b0; addr = a;
    chk("rd_ready_a", ready_a, 1);
    qa.push_back('{due: cyc + 1, data: {32'h0, model_ab[a]}});
    qb.push_back('{due: cyc + 2, data: {32'h0, model_ab[a]}});
    tick();
    req = 1'b0;
  endtask

  task automatic wr_c(input logic [3:0] a, input logic [63:0] d, input logic [7:0] b);
    req_c = 1'b1; we_c = 1'b1; addr_c = a; di_c = d; be_c = b;
    chk("wr_ready_c", ready_c, 1);
    tick();
    model_c[a] = merge(model_c[a], d, b);
    req_c = 1'b0;
  endtask

  task automatic rd_c(input logic [3:0] a);
    req_c = 1'b1; we_c = 1'b0; addr_c = a;
    chk("rd_ready_c", ready_c, 1);
    qc.push_back('{due: cyc + 1, data: model_c[a]});
    tick();
    req_c = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; be = '0; addr = '0; di = '0; clr = 1'b0;
    req_c = 1'b0; we_c = 1'b0; be_c = '0; addr_c = '0; di_c = '0; clr_c = 1'b0;
    cyc = 0; total = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      u_a.mem_q[i] = 32'hA5A5A5A5;
      u_b.mem_q[i] = 32'hA5A5A5A5;
      model_ab[i]  = '0;
      model_c[i]   = 'x;
    end

    tick();
    tick();
    chk("rst_busy_a", busy_a, 1);
    chk("rst_ready_a", ready_a, 0);
    chk("rst_do_a", do_a, 0);
    chk("rst_do_b", do_b, 0);
    chk("rst_busy_c", busy_c, 0);
    chk("rst_ready_c", ready_c, 1);
    chk("rst_do_c", do_c, 0);

    // Reset-driven clear over a preloaded array.
    rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) chk("c_ready_first_edge", ready_c, 1);
    end while (busy_a && n < 100);
    chk("reset_clear_len", n, 16);
    chk("ready_after_clear", ready_a, 1);
    chk("busy_b_after_clear", busy_b, 0);
    for (int i = 0; i < 16; i++) rd_ab(i[3:0]);
    tick();

    // Byte enables.
    wr_ab(4'd3, 32'h11223344, 4'hF);
    wr_ab(4'd3, 32'hAABBCCDD, 4'b0101);
    chk("be_model", model_ab[3], 32'h11BB33DD);
    rd_ab(4'd3);
    tick();
    tick();

    // Back-to-back write then two reads.
    wr_ab(4'd7, 32'hDEADBEEF, 4'hF);
    rd_ab(4'd7);
    rd_ab(4'd8);
    tick();
    tick();

    // Read just before a clear, then clr_i colliding with a write request.
    rd_ab(4'd3);
    clr = 1'b1; req = 1'b1; we = 1'b1; addr = 4'd2; di = 32'h55; be = 4'hF;
    #1;
    chk("collide_ready", ready_a, 0);
    tick();
    clr = 1'b0; req = 1'b0;
    chk("collide_busy", busy_a, 1);
    for (int i = 0; i < 16; i++) model_ab[i] = '0;
    // Hold a write request through the clear and re-pulse clr_i mid-way; both are ignored.
    req = 1'b1; we = 1'b1; addr = 4'd5; di = '1; be = '1;
    n = 0;
    do begin
      clr = (n == 3);
      if (n == 5) chk("clear_ready_low", ready_a, 0);
      tick();
      n++;
    end while (busy_a && n < 100);
    req = 1'b0; clr = 1'b0;
    chk("clr_pulse_clear_len", n, 16);
    rd_ab(4'd2);
    rd_ab(4'd5);
    rd_ab(4'd3);
    tick();
    tick();

    // Reset while a read is in flight on the 2-cycle bank.
    wr_ab(4'd7, 32'h12345678, 4'hF);
    req = 1'b1; we = 1'b0; addr = 4'd7;
    qa.push_back('{due: cyc + 1, data: {32'h0, model_ab[7]}});
    tick();
    req = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("abort_do_b", do_b, 0);
    chk("abort_busy_a", busy_a, 1);

    // Reset in the middle of a clear restarts it from word 0.
    rst = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_clear_busy", busy_a, 1);
    chk("mid_clear_cnt", u_a.clr_cnt_q, 9);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      u_a.mem_q[i] = 32'hA5A5A5A5;
      u_b.mem_q[i] = 32'hA5A5A5A5;
      model_ab[i]  = '0;
    end
    tick();
    rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy_a && n < 100);
    chk("restart_clear_len", n, 16);
    for (int i = 0; i < 16; i++) rd_ab(i[3:0]);
    tick();
    tick();

    // 64-bit bank without reset clear: upper-half byte enables over a prior zero.
    wr_c(4'd4, 64'h0, 8'hFF);
    wr_c(4'd4, 64'h0123456789ABCDEF, 8'hF0);
    chk("c_model", model_c[4], 64'h0123456700000000);
    rd_c(4'd4);
    tick();
    tick();

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("qc_drained", qc.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/user_sram_bank.md
# user_sram_bank

Parametrised single-port on-chip SRAM bank for the SoC's user memory region, replacing the fixed 32-bit word RAM. Adds configurable data width and depth, per-byte write enables, a fixed 1- or 2-cycle registered read pipeline with a valid strobe, and a hardware clear engine. The clear engine zeroes the array one word per cycle after reset or on request. The bank sits behind the bus adapter and is driven through a simple req/ready handshake. All outputs are always driven; there are no tri-state outputs.

## Interface
- DATA_W, 32: data width in bits; must be a multiple of 8 (checked at elaboration).
- ADDR_BIT, 8: address width; depth is 2**ADDR_BIT words.
- RD_LAT, 1: read latency in cycles; legal values are 1 or 2.
- CLEAR_ON_RESET, 1: 1 runs a full clear after reset; 0 comes up ready with array contents undefined.

Ports:
- clk_i  in  1  the single clock; everything is on its rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- req_i  in  1  access request.
- we_i  in  1  1 = write, 0 = read; sampled with req_i.
- be_i  in  DATA_W/8  byte enables for writes; ignored for reads.
- addr_i  in  ADDR_BIT  word address.
- di_i  in  DATA_W  write data.
- clr_i  in  1  one-cycle pulse that starts a full array clear.
- ready_o  out  1  the bank can accept a request this cycle.
- do_o  out  DATA_W  read data.
- rvalid_o  out  1  one-cycle strobe that marks do_o valid.
- busy_o  out  1  the clear engine is running.

## Operation
- The FSM has two states, IDLE and CLEAR, plus an ADDR_BIT-wide clear counter clr_cnt.
- On reset, state goes to CLEAR if CLEAR_ON_RESET=1, otherwise to IDLE. clr_cnt resets to 0.
- In CLEAR, every rising edge writes all-zero to word clr_cnt and increments clr_cnt.
- When clr_cnt = 2**ADDR_BIT-1 is written, the FSM moves to IDLE and clr_cnt wraps to 0. A clear therefore takes exactly 2**ADDR_BIT cycles.
- busy_o = (state==CLEAR).
- ready_o = (state==IDLE) && !clr_i. ready_o is combinational from state and clr_i only, never from req_i.
- A request is accepted on an edge where req_i && ready_o.
- Write accept: for each lane b with be_i[b]=1, mem[addr_i][8b+7:8b] <= di_i[8b+7:8b]. Lanes with be_i[b]=0 are unchanged. be_i = 0 is a legal no-op write. No rvalid_o is produced.
- Read accept: the request enters the read pipeline. rvalid_o pulses exactly RD_LAT cycles later, with do_o = mem[addr] as it was at the accept edge.
- do_o holds the last read data until the next read completes; it is never driven to X or Z.
- clr_i in IDLE moves the FSM to CLEAR on the next edge.
  - clr_i has priority over a same-cycle req_i; that request is not accepted and must be held by the master.
  - clr_i during CLEAR is ignored; the clear does not restart.
- Reads already in the pipeline when a clear starts complete normally with their pre-clear data.
- No requests are accepted during CLEAR; req_i is ignored there.

## Timing
- Reset values while rst_i is high, and immediately after release:
  - do_o = 0, rvalid_o = 0, read pipeline flushed.
  - busy_o = CLEAR_ON_RESET.
  - ready_o = !CLEAR_ON_RESET (and also gated by clr_i).
- Reset does not directly clear the array; clearing is done only by the CLEAR state.
- With CLEAR_ON_RESET=1, the first edge after release clears word 0. ready_o first rises after 2**ADDR_BIT edges.
- Reset asserted mid-clear restarts the clear from word 0.
- Reset asserted mid-read drops the read: no rvalid_o is produced.
- Throughput is one accepted request per cycle, in any mix of reads and writes.
- Read latency is RD_LAT edges from the accept edge to rvalid_o high.
  - RD_LAT=1: the array output is registered.
  - RD_LAT=2: an additional output register follows.
- Write followed by read of the same address on the next edge returns the new data.
- Read and write of the same address on the same edge is impossible, since the bank is single-port.
- addr_i covers exactly the full depth; there are no out-of-range addresses.
- clr_cnt wraps only at the CLEAR-to-IDLE transition.

## Test plan
- Reset clear, with DATA_W=32, ADDR_BIT=4, CLEAR_ON_RESET=1:
  - Preload the array via backdoor with 0xA5A5A5A5, pulse rst_i, then count cycles.
  - Required: busy_o=1 for exactly 16 edges, then ready_o=1. Reads of addresses 0..15 all return 0.
- Byte enables: write 0x11223344 with be=4'hF to addr 3, then 0xAABBCCDD with be=4'b0101 to addr 3, then read addr 3.
  - Required: do_o = 0x11BB33DD with rvalid_o exactly RD_LAT cycles after the read accept.
- Back-to-back traffic with RD_LAT=2: write addr 7 = 0xDEADBEEF, then on the next cycle read addr 7, then read addr 8 (value 0).
  - Required: rvalid_o high on two consecutive cycles, carrying 0xDEADBEEF then 0x00000000.
- clr_i collision: assert clr_i and req_i together (write addr 2 = 0x55).
  - Required: ready_o=0 that cycle, the write is not performed, busy_o rises next cycle, and after 16 cycles addr 2 reads 0.
  - Also issue a read one cycle before clr_i; it must return its pre-clear value.
- Reset mid-operation: issue a read, then assert rst_i before rvalid_o; separately, assert rst_i at clr_cnt=9 mid-clear.
  - Required: no rvalid_o after the aborted read.
  - After release from the mid-clear reset, the clear restarts at word 0 and lasts a full 16 cycles.
- CLEAR_ON_RESET=0 with DATA_W=64: ready_o=1 on the first edge after reset.
  - Write 0x0123456789ABCDEF with be=8'hF0, over a prior 0.
  - Required: readback = 0x0123456700000000.
